// File: rtl/sd_init_seq_if.sv
// Command-controller bus between the SD init sequencer (master) and the
// SD command engine (slave). Handshake: the master raises start for one
// cycle while busy==0; the engine raises busy after accepting, then pulses
// done for one cycle with timeout/syntaxe/resparg valid alongside done.
interface sd_init_seq_if;
  logic        sdclken;
  logic [15:0] clkdiv;
  logic        start;
  logic [15:0] precnt;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        syntaxe;
  logic [31:0] resparg;

  modport master (
    output sdclken, clkdiv, start, precnt, cmd, arg,
    input  busy, done, timeout, syntaxe, resparg
  );

  modport slave (
    input  sdclken, clkdiv, start, precnt, cmd, arg,
    output busy, done, timeout, syntaxe, resparg
  );
endinterface

// File: rtl/sd_init_seq.sv
// SD card identification sequencer: CMD0, [CMD8], CMD55/ACMD41 loop, CMD2,
// CMD3, CMD7. Define SD_INIT_CMD8_EN to issue CMD8 (SD v2 voltage check).
module sd_init_seq #(
  parameter logic [15:0] INIT_CLKDIV  = 16'd250,
  parameter logic [15:0] FAST_CLKDIV  = 16'd2,
  parameter logic [15:0] PRECNT_FIRST = 16'd80,
  parameter logic [15:0] PRECNT_CMD   = 16'd8,
  parameter logic [15:0] ACMD41_MAX   = 16'd1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_err,
  output logic [3:0]  err_code,
  output logic        card_ready,
  output logic        card_hc,
  output logic [15:0] rca,
  output logic [2:0]  dbg_state,
  sd_init_seq_if.master cmd_bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD2   = 6'd2;
  localparam logic [5:0] CMD3   = 6'd3;
  localparam logic [5:0] CMD7   = 6'd7;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
`ifdef SD_INIT_CMD8_EN
  localparam logic [5:0] CMD8   = 6'd8;
`endif

  logic [2:0]  state_q, state_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [15:0] precnt_q, precnt_d;
  logic        v2_q, v2_d;
  logic [15:0] attempt_q, attempt_d;
  logic        card_ready_q, card_ready_d;
  logic        card_hc_q, card_hc_d;
  logic [15:0] rca_q, rca_d;
  logic [3:0]  err_code_q, err_code_d;
  logic        done_pulse_q, done_pulse_d;
  logic        err_pulse_q, err_pulse_d;
  logic        tmo_q, tmo_d;
  logic        syn_q, syn_d;
  logic [15:0] rsp_hi_q, rsp_hi_d;
`ifdef SD_INIT_CMD8_EN
  logic [11:0] rsp_lo_q, rsp_lo_d;
`endif

  logic        issue;
  logic [5:0]  nxt_cmd;
  logic [31:0] nxt_arg;
  logic        fail;
  logic [3:0]  fail_code;
  logic        rsp_err;
  logic [15:0] attempt_inc;

  assign rsp_err     = tmo_q | syn_q;
  assign attempt_inc = (attempt_q == 16'hFFFF) ? attempt_q : attempt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    precnt_d     = precnt_q;
    v2_d         = v2_q;
    attempt_d    = attempt_q;
    card_ready_d = card_ready_q;
    card_hc_d    = card_hc_q;
    rca_d        = rca_q;
    err_code_d   = err_code_q;
    done_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    tmo_d        = tmo_q;
    syn_d        = syn_q;
    rsp_hi_d     = rsp_hi_q;
`ifdef SD_INIT_CMD8_EN
    rsp_lo_d     = rsp_lo_q;
`endif
    issue        = 1'b0;
    nxt_cmd      = CMD0;
    nxt_arg      = 32'h0;
    fail         = 1'b0;
    fail_code    = 4'h0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (init_start) begin
          card_ready_d = 1'b0;
          card_hc_d    = 1'b0;
          rca_d        = 16'h0;
          err_code_d   = 4'h0;
          attempt_d    = 16'h0;
          v2_d         = 1'b0;
          issue        = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!cmd_bus.busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cmd_bus.done) begin
          tmo_d    = cmd_bus.timeout;
          syn_d    = cmd_bus.syntaxe;
          rsp_hi_d = cmd_bus.resparg[31:16];
`ifdef SD_INIT_CMD8_EN
          rsp_lo_d = cmd_bus.resparg[11:0];
`endif
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        case (cmd_q)
          CMD0: begin
            // No response is expected to GO_IDLE, so any outcome is accepted.
            issue = 1'b1;
`ifdef SD_INIT_CMD8_EN
            nxt_cmd = CMD8;
            nxt_arg = 32'h0000_01AA;
`else
            nxt_cmd = CMD55;
`endif
          end
`ifdef SD_INIT_CMD8_EN
          CMD8: begin
            // Silence means a v1 card; a wrong echo means an unusable card.
            if (tmo_q) begin
              v2_d    = 1'b0;
              issue   = 1'b1;
              nxt_cmd = CMD55;
            end else if (!syn_q && rsp_lo_q == 12'h1AA) begin
              v2_d    = 1'b1;
              issue   = 1'b1;
              nxt_cmd = CMD55;
            end else begin
              fail      = 1'b1;
              fail_code = 4'h1;
            end
          end
`endif
          CMD55: begin
            if (rsp_err) begin
              fail      = 1'b1;
              fail_code = 4'h2;
            end else begin
              issue   = 1'b1;
              nxt_cmd = ACMD41;
              nxt_arg = {1'b0, v2_q, 6'b0, 24'hFF8000};
            end
          end
          ACMD41: begin
            // R3 carries no CRC, so syntaxe is not meaningful here.
            if (tmo_q) begin
              fail      = 1'b1;
              fail_code = 4'h3;
            end else if (rsp_hi_q[15]) begin
              card_hc_d = rsp_hi_q[14];
              issue     = 1'b1;
              nxt_cmd   = CMD2;
            end else begin
              attempt_d = attempt_inc;
              if (attempt_inc >= ACMD41_MAX) begin
                fail      = 1'b1;
                fail_code = 4'h4;
              end else begin
                issue   = 1'b1;
                nxt_cmd = CMD55;
              end
            end
          end
          CMD2: begin
            if (rsp_err) begin
              fail      = 1'b1;
              fail_code = 4'h5;
            end else begin
              issue   = 1'b1;
              nxt_cmd = CMD3;
            end
          end
          CMD3: begin
            if (rsp_err) begin
              fail      = 1'b1;
              fail_code = 4'h6;
            end else begin
              rca_d   = rsp_hi_q;
              issue   = 1'b1;
              nxt_cmd = CMD7;
              nxt_arg = {rsp_hi_q, 16'h0};
            end
          end
          CMD7: begin
            if (rsp_err) begin
              fail      = 1'b1;
              fail_code = 4'h7;
            end else begin
              state_d      = S_DONE;
              done_pulse_d = 1'b1;
              card_ready_d = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      state_d      = S_ERR;
      err_code_d   = fail_code;
      err_pulse_d  = 1'b1;
      card_ready_d = 1'b0;
    end

    // cmd/arg/precnt are loaded once on entry to ISSUE and held until the next command.
    if (issue) begin
      state_d  = S_ISSUE;
      cmd_d    = nxt_cmd;
      arg_d    = nxt_arg;
      precnt_d = (nxt_cmd == CMD0) ? PRECNT_FIRST : PRECNT_CMD;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cmd_q        <= 6'h0;
      arg_q        <= 32'h0;
      precnt_q     <= 16'h0;
      v2_q         <= 1'b0;
      attempt_q    <= 16'h0;
      card_ready_q <= 1'b0;
      card_hc_q    <= 1'b0;
      rca_q        <= 16'h0;
      err_code_q   <= 4'h0;
      done_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      tmo_q        <= 1'b0;
      syn_q        <= 1'b0;
      rsp_hi_q     <= 16'h0;
`ifdef SD_INIT_CMD8_EN
      rsp_lo_q     <= 12'h0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      precnt_q     <= precnt_d;
      v2_q         <= v2_d;
      attempt_q    <= attempt_d;
      card_ready_q <= card_ready_d;
      card_hc_q    <= card_hc_d;
      rca_q        <= rca_d;
      err_code_q   <= err_code_d;
      done_pulse_q <= done_pulse_d;
      err_pulse_q  <= err_pulse_d;
      tmo_q        <= tmo_d;
      syn_q        <= syn_d;
      rsp_hi_q     <= rsp_hi_d;
`ifdef SD_INIT_CMD8_EN
      rsp_lo_q     <= rsp_lo_d;
`endif
    end
  end

  assign init_busy  = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_EVAL);
  assign init_done  = done_pulse_q;
  assign init_err   = err_pulse_q;
  assign err_code   = err_code_q;
  assign card_ready = card_ready_q;
  assign card_hc    = card_hc_q;
  assign rca        = rca_q;
  assign dbg_state  = state_q;

  assign cmd_bus.sdclken = init_busy || (state_q == S_DONE);
  assign cmd_bus.clkdiv  = (state_q == S_DONE) ? FAST_CLKDIV : INIT_CLKDIV;
  assign cmd_bus.start   = (state_q == S_ISSUE) && !cmd_bus.busy;
  assign cmd_bus.precnt  = precnt_q;
  assign cmd_bus.cmd     = cmd_q;
  assign cmd_bus.arg     = arg_q;

endmodule
